// File: rtl/cache_definition.sv
// Shared definitions for the N-way set-associative cache: controller state
// encoding and the address-field width helpers.
package cache_definition;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESP,
    ST_FLUSH_SCAN,
    ST_FLUSH_WB
  } cache_state_e;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int line_words, input int sets);
    return addr_w - 2 - offset_bits(line_words) - index_bits(sets);
  endfunction

  // Storage width for a field that may legitimately be zero bits wide.
  function automatic int safe_w(input int w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/cache_lru_nway.sv
// True-LRU age tracker: one age per way per set, kept as a permutation of
// 0..WAYS-1. Age 0 is most recent; the oldest way is the victim.
module cache_lru_nway
  import cache_definition::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  localparam int WAY_W = safe_w($clog2(WAYS)),
  localparam int SET_W = safe_w($clog2(SETS))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic [SET_W-1:0] vic_set,
  output logic [WAY_W-1:0] vic_way
);

  typedef logic [WAYS-1:0][WAY_W-1:0] set_ages_t;

  function automatic set_ages_t init_ages();
    set_ages_t r;
    for (int w = 0; w < WAYS; w++) r[w] = WAY_W'(w);
    return r;
  endfunction

  localparam set_ages_t AGE_INIT = init_ages();

  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q;
  logic [WAY_W-1:0]                     old_age;
  logic [WAY_W-1:0]                     best;

  assign old_age = age_q[acc_set][acc_way];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= {SETS{AGE_INIT}};
    end else if (acc_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == acc_way)
          age_q[acc_set][w] <= '0;
        else if (age_q[acc_set][w] < old_age)
          age_q[acc_set][w] <= age_q[acc_set][w] + WAY_W'(1);
      end
    end
  end

  always_comb begin
    vic_way = '0;
    best    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[vic_set][w] > best) begin
        best    = age_q[vic_set][w];
        vic_way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/sa_cache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with
// multi-word lines, true-LRU replacement, byte-enabled writes and flush.
module sa_cache_nway
  import cache_definition::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_valid,
  input  logic                cpu_rw,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic                flush_req,
  output logic                cpu_ready,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                flush_done,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data_w,
  input  logic [DATA_W-1:0]   ram_data_r
);

  localparam int BE_W   = DATA_W / 8;
  localparam int OFF_W  = offset_bits(LINE_WORDS);
  localparam int IDX_W  = index_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, LINE_WORDS, SETS);
  localparam int OFF_SW = safe_w(OFF_W);
  localparam int IDX_SW = safe_w(IDX_W);
  localparam int WAY_W  = safe_w($clog2(WAYS));
  localparam int CNT_W  = $clog2(LINE_WORDS + 1);
  localparam int WA_W   = ADDR_W - 2;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cpu_req_t;

  cache_state_e state_q, state_d;
  cpu_req_t     req_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WAY_W-1:0]  vway_q;
  logic [IDX_SW-1:0] fset_q;
  logic [WAY_W-1:0]  fway_q;
  logic [DATA_W-1:0] rdata_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_arr [SETS][WAYS];
  logic [DATA_W-1:0] data_arr [SETS][WAYS][LINE_WORDS];

  logic [WA_W-1:0]   req_wa;
  logic [OFF_SW-1:0] req_off, cnt_word;
  logic [IDX_SW-1:0] req_idx, wb_set;
  logic [TAG_W-1:0]  req_tag;
  logic              hit, inv_found, fl_dirty, fl_last;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_vic, victim, wb_way;
  logic              unused_bits;

  assign req_wa      = req_q.addr[ADDR_W-1:2];
  assign req_off     = (OFF_W == 0) ? '0 : OFF_SW'(req_wa);
  assign req_idx     = (IDX_W == 0) ? '0 : IDX_SW'(req_wa >> OFF_W);
  assign req_tag     = TAG_W'(req_wa >> (OFF_W + IDX_W));
  assign unused_bits = ^req_q.addr[1:0];
  assign cnt_word    = OFF_SW'(cnt_q);

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0]  t,
                                                input logic [IDX_SW-1:0] i,
                                                input logic [OFF_SW-1:0] o);
    logic [WA_W-1:0] wa;
    wa = WA_W'(t) << (IDX_W + OFF_W);
    if (IDX_W > 0) wa = wa | (WA_W'(i) << OFF_W);
    if (OFF_W > 0) wa = wa | WA_W'(o);
    return {wa, 2'b00};
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  cache_lru_nway #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk     (clk),
    .rst     (rst),
    .acc_en  (state_q == ST_COMPARE && hit),
    .acc_set (req_idx),
    .acc_way (hit_way),
    .vic_set (req_idx),
    .vic_way (lru_vic)
  );

  // Hit detect and lowest-index invalid way; invalid ways win over LRU.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim   = inv_found ? inv_way : lru_vic;
  assign fl_dirty = dirty_q[fset_q][fway_q];
  assign fl_last  = (fset_q == IDX_SW'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));
  assign wb_set   = (state_q == ST_FLUSH_WB) ? fset_q : req_idx;
  assign wb_way   = (state_q == ST_FLUSH_WB) ? fway_q : vway_q;
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    flush_done = 1'b0;
    ram_we     = 1'b0;
    ram_be     = '0;
    ram_addr   = '0;
    ram_data_w = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req)      state_d = ST_FLUSH_SCAN;
        else if (cpu_valid) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (hit)                         state_d = ST_RESP;
        else if (dirty_q[req_idx][victim]) state_d = ST_WRITEBACK;
        else                             state_d = ST_REFILL;
      end
      ST_WRITEBACK, ST_FLUSH_WB: begin
        ram_we     = 1'b1;
        ram_be     = '1;
        ram_addr   = mk_addr(tag_arr[wb_set][wb_way], wb_set, cnt_word);
        ram_data_w = data_arr[wb_set][wb_way][cnt_word];
        if (cnt_q == CNT_W'(LINE_WORDS - 1))
          state_d = (state_q == ST_WRITEBACK) ? ST_REFILL : ST_FLUSH_SCAN;
      end
      ST_REFILL: begin
        // Last cycle only captures the final word; no new read is issued.
        if (cnt_q == CNT_W'(LINE_WORDS)) state_d = ST_COMPARE;
        else ram_addr = mk_addr(req_tag, req_idx, cnt_word);
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_FLUSH_SCAN: begin
        if (fl_dirty) begin
          state_d = ST_FLUSH_WB;
        end else if (fl_last) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      cnt_q   <= '0;
      vway_q  <= '0;
      fset_q  <= '0;
      fway_q  <= '0;
      rdata_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (flush_req) begin
            fset_q <= '0;
            fway_q <= '0;
          end else if (cpu_valid) begin
            req_q <= {cpu_rw, cpu_addr, cpu_wdata, cpu_be};
          end
        end
        ST_COMPARE: begin
          cnt_q <= '0;
          if (hit) begin
            if (req_q.rw) dirty_q[req_idx][hit_way] <= 1'b1;
            else          rdata_q <= data_arr[req_idx][hit_way][req_off];
          end else begin
            vway_q <= victim;
          end
        end
        ST_WRITEBACK: begin
          cnt_q <= (cnt_q == CNT_W'(LINE_WORDS - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
        ST_REFILL: begin
          if (cnt_q == CNT_W'(LINE_WORDS)) begin
            cnt_q                   <= '0;
            valid_q[req_idx][vway_q] <= 1'b1;
            dirty_q[req_idx][vway_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FLUSH_SCAN: begin
          cnt_q <= '0;
          // After a write-back the same slot is rescanned, now clean.
          if (!fl_dirty && !fl_last) begin
            if (fway_q == WAY_W'(WAYS - 1)) begin
              fway_q <= '0;
              fset_q <= fset_q + IDX_SW'(1);
            end else begin
              fway_q <= fway_q + WAY_W'(1);
            end
          end
        end
        ST_FLUSH_WB: begin
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            cnt_q                  <= '0;
            dirty_q[fset_q][fway_q] <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; valid bits guard stale contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_COMPARE && hit && req_q.rw)
      data_arr[req_idx][hit_way][req_off] <=
        merge(data_arr[req_idx][hit_way][req_off], req_q.wdata, req_q.be);
    if (state_q == ST_REFILL) begin
      if (cnt_q != '0)
        data_arr[req_idx][vway_q][OFF_SW'(cnt_q - CNT_W'(1))] <= ram_data_r;
      if (cnt_q == CNT_W'(LINE_WORDS))
        tag_arr[req_idx][vway_q] <= req_tag;
    end
  end

endmodule

// File: tb/tb_sa_cache_nway.sv
// Scoreboard bench for sa_cache_nway: a coherent reference memory predicts
// read data and write-back traffic; a RAM model backs the cache.
module tb_sa_cache_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid, cpu_rw, flush_req;
  logic [19:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready, flush_done, ram_we;
  logic [31:0] cpu_rdata, ram_data_w, ram_data_r;
  logic [3:0]  ram_be;
  logic [19:0] ram_addr;

  always #5 clk = ~clk;

  sa_cache_nway dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .flush_req(flush_req), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .flush_done(flush_done), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_data_w(ram_data_w), .ram_data_r(ram_data_r)
  );

  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] mem     [0:262143];
  logic [31:0] ref_mem [0:262143];
  logic [31:0] exp_q[$];
  wr_t         wr_q[$];
  wr_t         mon_e;
  logic [19:0] rd_log[$];
  logic        log_en = 1'b0;
  int          n_cmp = 0, n_err = 0, wr_cnt = 0;

  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[19:2]][8*b +: 8] <= ram_data_w[8*b +: 8];
    ram_data_r <= mem[ram_addr[19:2]];
  end

  // Every RAM write must match the next expected write-back word.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_cnt++;
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ram_write addr=%h data=%h", ram_addr, ram_data_w);
      end else begin
        mon_e = wr_q.pop_front();
        if (ram_addr !== mon_e.a || ram_data_w !== mon_e.d || ram_be !== 4'hF) begin
          n_err++;
          $display("FAIL ram_write got addr=%h data=%h be=%h want addr=%h data=%h be=f",
                   ram_addr, ram_data_w, ram_be, mon_e.a, mon_e.d);
        end
      end
    end else if (log_en) begin
      rd_log.push_back(ram_addr);
    end
  end

  function automatic bit log_has(input logic [19:0] base);
    for (int i = 0; i + 3 < rd_log.size(); i++)
      if (rd_log[i] == base && rd_log[i+1] == base + 20'd4 &&
          rd_log[i+2] == base + 20'd8 && rd_log[i+3] == base + 20'd12)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit log_all_zero();
    foreach (rd_log[i]) if (rd_log[i] != 20'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_wb(input logic [19:0] base);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      e.a = base + 20'(4 * i);
      e.d = ref_mem[base[19:2] + 18'(i)];
      wr_q.push_back(e);
    end
  endtask

  task automatic do_req(input logic rw, input logic [19:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int lat);
    logic [31:0] exp;
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    if (rw) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[19:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      exp_q.push_back(ref_mem[a[19:2]]);
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ready && lat < 200);
    if (!cpu_ready) begin
      n_cmp++; n_err++;
      $display("FAIL req_timeout addr=%h got no cpu_ready within %0d cycles", a, lat);
      if (!rw) void'(exp_q.pop_front());
    end else if (!rw) begin
      exp = exp_q.pop_front();
      n_cmp++;
      if (cpu_rdata !== exp) begin
        n_err++;
        $display("FAIL rdata addr=%h got %h want %h", a, cpu_rdata, exp);
      end
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_pulse addr=%h got %b want 0", a, cpu_ready);
    end
  endtask

  task automatic check_lat(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({cpu_ready, flush_done, ram_we, ram_be, ram_addr, cpu_rdata, ram_data_w} !== '0) begin
      n_err++;
      $display("FAIL %s outputs got rdy=%b fd=%b we=%b be=%h addr=%h rdata=%h wdata=%h want all 0",
               name, cpu_ready, flush_done, ram_we, ram_be, ram_addr, cpu_rdata, ram_data_w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_valid = 0; cpu_rw = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0; flush_req = 0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_cold_read();
    int lat, w0;
    w0 = wr_cnt;
    rd_log.delete(); log_en = 1'b1;
    do_req(1'b0, 20'h00008, '0, '0, lat);
    log_en = 1'b0;
    check_lat("cold_read", lat, 8);
    n_cmp++;
    if (!log_has(20'h00000)) begin
      n_err++; $display("FAIL cold_read_refill_addrs got none want 0,4,8,c in order");
    end
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++; $display("FAIL cold_read_writes got %0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_hit_read();
    int lat;
    rd_log.delete(); log_en = 1'b1;
    do_req(1'b0, 20'h0000C, '0, '0, lat);
    log_en = 1'b0;
    check_lat("hit_read", lat, 2);
    n_cmp++;
    if (!log_all_zero()) begin
      n_err++; $display("FAIL hit_read_ram_access got address traffic want none");
    end
  endtask

  task automatic test_byte_enable();
    int lat, w0;
    w0 = wr_cnt;
    do_req(1'b1, 20'h00004, 32'h1122_3344, 4'b0110, lat);
    check_lat("be_write", lat, 2);
    do_req(1'b0, 20'h00004, '0, '0, lat);
    check_lat("be_read", lat, 2);
    do_req(1'b1, 20'h00008, 32'hFFFF_FFFF, 4'b0000, lat);
    do_req(1'b0, 20'h00008, '0, '0, lat);
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++; $display("FAIL be_writes got %0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_lru_evict();
    int lat, w0;
    do_req(1'b1, 20'h00000, 32'hA5A5_A5A5, 4'hF, lat);
    do_req(1'b0, 20'h00400, '0, '0, lat);
    check_lat("load_400", lat, 8);
    do_req(1'b0, 20'h00000, '0, '0, lat);
    check_lat("reread_000", lat, 2);
    w0 = wr_cnt;
    do_req(1'b0, 20'h00800, '0, '0, lat);
    check_lat("evict_clean", lat, 8);
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++; $display("FAIL evict_clean_writes got %0d want 0", wr_cnt - w0);
    end
    push_wb(20'h00000);
    w0 = wr_cnt;
    do_req(1'b0, 20'h00400, '0, '0, lat);
    check_lat("evict_dirty", lat, 12);
    n_cmp++;
    if (wr_cnt - w0 != 4 || wr_q.size() != 0) begin
      n_err++; $display("FAIL evict_dirty_writes got %0d left %0d want 4 left 0",
                        wr_cnt - w0, wr_q.size());
    end
  endtask

  task automatic wait_flush(input string name, output int cyc, output bit early_rdy);
    cyc = 0; early_rdy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cpu_ready) early_rdy = 1;
    end while (!flush_done && cyc < 1000);
    n_cmp++;
    if (!flush_done || early_rdy) begin
      n_err++;
      $display("FAIL %s_done got done=%b ready_seen=%b want done=1 ready_seen=0",
               name, flush_done, early_rdy);
    end
  endtask

  task automatic test_flush();
    int lat, w0, cyc, k;
    bit  er;
    logic [31:0] exp;
    do_req(1'b1, 20'h00400, 32'h0BAD_F00D, 4'hF, lat);
    do_req(1'b1, 20'h00010, 32'h1234_5678, 4'hF, lat);
    check_lat("write_set1_miss", lat, 8);
    push_wb(20'h00400);
    push_wb(20'h00010);
    w0 = wr_cnt;
    @(posedge clk); #1;
    flush_req = 1'b1; cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h00800;
    exp_q.push_back(ref_mem[20'h00800 >> 2]);
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_flush("flush1", cyc, er);
    n_cmp++;
    if (wr_cnt - w0 != 8 || wr_q.size() != 0) begin
      n_err++; $display("FAIL flush1_writes got %0d left %0d want 8 left 0",
                        wr_cnt - w0, wr_q.size());
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_ready && k < 50);
    check_lat("pending_after_flush", k, 3);
    exp = exp_q.pop_front();
    n_cmp++;
    if (cpu_rdata !== exp) begin
      n_err++; $display("FAIL pending_rdata got %h want %h", cpu_rdata, exp);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    w0 = wr_cnt;
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_flush("flush2", cyc, er);
    n_cmp++;
    if (wr_cnt != w0) begin
      n_err++; $display("FAIL flush2_writes got %0d want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    do_req(1'b0, 20'h00C00, '0, '0, lat);
    check_lat("load_c00", lat, 8);
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 20'h00400;
    @(posedge clk);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ram_addr !== 20'h00408) begin
      n_err++; $display("FAIL third_refill_addr got %h want 00408", ram_addr);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_refill_reset");
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_log.delete(); log_en = 1'b1;
    do_req(1'b0, 20'h00400, '0, '0, lat);
    log_en = 1'b0;
    check_lat("reread_after_reset", lat, 8);
    n_cmp++;
    if (!log_has(20'h00400)) begin
      n_err++; $display("FAIL reread_refill_addrs got none want 400,404,408,40c in order");
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem[i]     = 32'hD000_0000 | 32'(i << 2);
      ref_mem[i] = 32'hD000_0000 | 32'(i << 2);
    end
    test_reset();
    test_cold_read();
    test_hit_read();
    test_byte_enable();
    test_lru_evict();
    test_flush();
    test_reset_mid_refill();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover_expectations got wr=%0d rd=%0d want 0 0",
                        wr_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
